alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- EX/WB pipeline stage directly downstream of the 24-bit ALU.
- Registers the ALU's Result_final, Mul_result and status outputs together with the destination-register tag.
- Owns the architectural HI/LO multiply registers and the sticky flag register.
- Presents one write-back entry to the register file under a valid/ready handshake, with flush and overflow-trap support.

Parameters:
DATA_W, 24, datapath width; HI and LO are each DATA_W wide
RD_W, 4, destination register index width

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
InValid  in  1  upstream entry valid this cycle
InReady  out  1  stage can accept an entry this cycle
Result_final  in  DATA_W  ALU result
Mul_result  in  2*DATA_W  ALU product; HI = [47:24], LO = [23:0]
Zero  in  1  ALU zero flag
Overflow  in  1  ALU overflow flag
CarryOut  in  1  ALU carry-out
RegWriteIn  in  1  entry writes the register file
RdIn  in  RD_W  destination register
MulWrite  in  1  entry commits Mul_result into HI/LO
MfHi  in  1  write-back data comes from HI instead of Result_final
MfLo  in  1  write-back data comes from LO instead of Result_final
FlagWrite  in  1  entry updates the flag register
TrapEn  in  1  overflow on this entry raises a trap
Flush  in  1  kill the held entry and block capture this cycle
OutReady  in  1  consumer accepts the held entry
OutValid  out  1  held entry valid
WbData  out  DATA_W  write-back data
WbRd  out  RD_W  write-back register
WbRegWrite  out  1  register-file write enable; already gated by OutValid
Hi  out  DATA_W  HI register
Lo  out  DATA_W  LO register
Flags  out  3  sticky flags {Overflow, CarryOut, Zero}
OverflowTrap  out  1  one-cycle trap pulse

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - OutValid, WbData, WbRd, WbRegWrite, Hi, Lo, Flags and OverflowTrap all go to 0.
  - InReady = 1 once Reset deasserts.
- Handshake:
  - InReady = ~OutValid | OutReady (combinational).
  - Capture occurs when InValid & InReady & ~Flush.
  - Latency is 1 cycle: an entry captured in cycle N is visible on the outputs in cycle N+1.
- Holding: while OutValid & ~OutReady, every output field stays stable.
- Write-back data selection, evaluated at capture:
  - MfHi → current Hi, sampled before any same-cycle update.
  - else MfLo → current Lo.
  - else Result_final.
  - MfHi & MfLo together: MfHi wins.
- HI/LO: on capture with MulWrite, Hi <= Mul_result[47:24] and Lo <= Mul_result[23:0]. An entry captured in cycle N+1 with MfHi sees the value committed in cycle N (no hazard).
- Flags: on capture with FlagWrite, Flags <= {Overflow, CarryOut, Zero}; otherwise Flags hold.
- Overflow trap:
  - Condition is capture & TrapEn & Overflow.
  - OverflowTrap pulses high in cycle N+1 for exactly 1 cycle.
  - The held entry's WbRegWrite is forced to 0; OutValid is still 1 so the entry drains.
  - HI/LO and Flags still update.
- WbRegWrite = stored RegWriteIn & ~trap, and is 0 whenever OutValid = 0.
- Flush:
  - Next cycle OutValid = 0 and WbRegWrite = 0.
  - A same-cycle InValid is not captured and causes no HI/LO, Flags or trap side effects.
  - HI/LO and Flags committed by an earlier capture are not rolled back.
- Simultaneous drain and capture (OutValid & OutReady & InValid): the new entry replaces the old one back-to-back with no bubble, giving full throughput.
- Reset mid-operation: the held entry is lost and no write-back is issued.

Decomposition:
- Shared package cpu24_pkg holds:
  - DATA_W and RD_W defaults.
  - Flag bit indices: FLAG_Z = 0, FLAG_C = 1, FLAG_V = 2.
- One sub-module, hilo_regs: HI/LO storage with async reset, a write enable, a 48-bit write port and two 24-bit read ports.
- Handshake, write-back mux and trap logic stay in the top module.

Test Plan:
- Reset while OutValid=1 → all outputs 0 immediately, InReady=1 after deassert, no WbRegWrite.
- Capture with InValid=1, Result_final=24'h00ABCD, RdIn=5, RegWriteIn=1, OutReady=1 → next cycle OutValid=1, WbData=00ABCD, WbRd=5, WbRegWrite=1. Then hold OutReady=0 for 3 cycles with new InValid → InReady=0, outputs stable, no capture.
- MUL then MFHI/MFLO: Mul_result=48'h000001_FFFFFE with MulWrite=1 → Hi=000001, Lo=FFFFFE. The following entry with MfHi=1 gives WbData=000001; the next with MfLo=1 gives WbData=FFFFFE.
- Overflow trap: Result_final=24'h800000, Overflow=1, TrapEn=1, RegWriteIn=1, FlagWrite=1 → OverflowTrap high for 1 cycle, WbRegWrite=0, OutValid=1, Flags=3'b100.
- Flush with InValid=1 and MulWrite=1 in the same cycle → OutValid=0 next cycle, Hi/Lo unchanged, no trap.
- Back-to-back stream of 4 entries with OutReady=1 → OutValid high 4 consecutive cycles, WbData in order, InReady never deasserts.

Source files
------------

// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit CPU datapath: default widths and flag-register layout.
package cpu24_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int RD_W_DEF   = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;

    // Places the ALU status bits at their architectural positions in the flag register.
    function automatic logic [2:0] pack_flags(input logic v, input logic c, input logic z);
        logic [2:0] f;
        f         = 3'b000;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_wb_stage_hilo_regs.sv
// Architectural HI/LO multiply registers: one 2*DATA_W write port, separate HI and LO read ports.
module hilo_regs
    import cpu24_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo
);

    logic [DATA_W-1:0] hi_d, hi_q;
    logic [DATA_W-1:0] lo_d, lo_q;

    // Next-state: load the product halves on a write, otherwise hold.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (we) begin
            hi_d = wdata[2*DATA_W-1:DATA_W];
            lo_d = wdata[DATA_W-1:0];
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= {DATA_W{1'b0}};
            lo_q <= {DATA_W{1'b0}};
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/alu_wb_stage.sv
// EX/WB pipeline register behind the 24-bit ALU: one held write-back entry under valid/ready,
// with HI/LO and sticky flag ownership, flush and overflow trap.
module alu_wb_stage
    import cpu24_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [DATA_W-1:0]     Result_final,
    input  logic [2*DATA_W-1:0]   Mul_result,
    input  logic                  Zero,
    input  logic                  Overflow,
    input  logic                  CarryOut,
    input  logic                  RegWriteIn,
    input  logic [RD_W-1:0]       RdIn,
    input  logic                  MulWrite,
    input  logic                  MfHi,
    input  logic                  MfLo,
    input  logic                  FlagWrite,
    input  logic                  TrapEn,
    input  logic                  Flush,
    input  logic                  OutReady,
    output logic                  OutValid,
    output logic [DATA_W-1:0]     WbData,
    output logic [RD_W-1:0]       WbRd,
    output logic                  WbRegWrite,
    output logic [DATA_W-1:0]     Hi,
    output logic [DATA_W-1:0]     Lo,
    output logic [2:0]            Flags,
    output logic                  OverflowTrap
);

    logic                  out_valid_d, out_valid_q;
    logic [DATA_W-1:0]     wb_data_d, wb_data_q;
    logic [RD_W-1:0]       wb_rd_d, wb_rd_q;
    logic                  wb_regwrite_d, wb_regwrite_q;
    logic [2:0]            flags_d, flags_q;
    logic                  trap_d, trap_q;

    logic                  in_ready_s;
    logic                  capture_s;
    logic                  trap_s;
    logic                  mul_we_s;
    logic [DATA_W-1:0]     hi_s, lo_s;
    logic [DATA_W-1:0]     wb_sel_s;

    assign in_ready_s = ~out_valid_q | OutReady;
    assign capture_s  = InValid & in_ready_s & ~Flush;
    assign trap_s     = capture_s & TrapEn & Overflow;
    assign mul_we_s   = capture_s & MulWrite;

    hilo_regs #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk   (Clock),
        .rst   (Reset),
        .we    (mul_we_s),
        .wdata (Mul_result),
        .hi    (hi_s),
        .lo    (lo_s)
    );

    // Write-back source select; HI/LO are read from the registers, so a same-cycle MUL is not seen.
    always_comb begin
        wb_sel_s = Result_final;
        if (MfHi) begin
            wb_sel_s = hi_s;
        end else if (MfLo) begin
            wb_sel_s = lo_s;
        end else begin
            wb_sel_s = Result_final;
        end
    end

    // Next-state for the held entry, sticky flags and trap pulse.
    always_comb begin
        out_valid_d   = out_valid_q;
        wb_data_d     = wb_data_q;
        wb_rd_d       = wb_rd_q;
        wb_regwrite_d = wb_regwrite_q;
        if (Flush) begin
            out_valid_d   = 1'b0;
            wb_regwrite_d = 1'b0;
        end else if (capture_s) begin
            out_valid_d   = 1'b1;
            wb_data_d     = wb_sel_s;
            wb_rd_d       = RdIn;
            wb_regwrite_d = RegWriteIn & ~trap_s;
        end else if (OutReady) begin
            out_valid_d   = 1'b0;
            wb_regwrite_d = 1'b0;
        end else begin
            out_valid_d   = out_valid_q;
            wb_regwrite_d = wb_regwrite_q;
        end

        flags_d = flags_q;
        if (capture_s & FlagWrite) begin
            flags_d = pack_flags(Overflow, CarryOut, Zero);
        end else begin
            flags_d = flags_q;
        end

        trap_d = trap_s;
    end

    // Pipeline and status registers with asynchronous clear.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            out_valid_q   <= 1'b0;
            wb_data_q     <= {DATA_W{1'b0}};
            wb_rd_q       <= {RD_W{1'b0}};
            wb_regwrite_q <= 1'b0;
            flags_q       <= 3'b000;
            trap_q        <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            wb_data_q     <= wb_data_d;
            wb_rd_q       <= wb_rd_d;
            wb_regwrite_q <= wb_regwrite_d;
            flags_q       <= flags_d;
            trap_q        <= trap_d;
        end
    end

    assign InReady      = in_ready_s;
    assign OutValid     = out_valid_q;
    assign WbData       = wb_data_q;
    assign WbRd         = wb_rd_q;
    assign WbRegWrite   = wb_regwrite_q;
    assign Hi           = hi_s;
    assign Lo           = lo_s;
    assign Flags        = flags_q;
    assign OverflowTrap = trap_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed-vector bench for alu_wb_stage with hand-computed expectations.
module tb_alu_wb_stage;

    logic        Clock;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [23:0] Result_final;
    logic [47:0] Mul_result;
    logic        Zero, Overflow, CarryOut;
    logic        RegWriteIn;
    logic [3:0]  RdIn;
    logic        MulWrite, MfHi, MfLo, FlagWrite, TrapEn, Flush, OutReady;
    logic        OutValid;
    logic [23:0] WbData;
    logic [3:0]  WbRd;
    logic        WbRegWrite;
    logic [23:0] Hi, Lo;
    logic [2:0]  Flags;
    logic        OverflowTrap;

    int checks_total  = 0;
    int checks_passed = 0;

    alu_wb_stage dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .Result_final(Result_final), .Mul_result(Mul_result), .Zero(Zero),
        .Overflow(Overflow), .CarryOut(CarryOut), .RegWriteIn(RegWriteIn),
        .RdIn(RdIn), .MulWrite(MulWrite), .MfHi(MfHi), .MfLo(MfLo),
        .FlagWrite(FlagWrite), .TrapEn(TrapEn), .Flush(Flush), .OutReady(OutReady),
        .OutValid(OutValid), .WbData(WbData), .WbRd(WbRd), .WbRegWrite(WbRegWrite),
        .Hi(Hi), .Lo(Lo), .Flags(Flags), .OverflowTrap(OverflowTrap)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        InValid = 1'b0; Result_final = 24'h000000; Mul_result = 48'h0;
        Zero = 1'b0; Overflow = 1'b0; CarryOut = 1'b0; RegWriteIn = 1'b0;
        RdIn = 4'd0; MulWrite = 1'b0; MfHi = 1'b0; MfLo = 1'b0;
        FlagWrite = 1'b0; TrapEn = 1'b0; Flush = 1'b0; OutReady = 1'b1;
    endtask

    initial begin
        idle_inputs();
        Reset = 1'b1;
        step();
        step();
        check_eq("rst_outvalid", {47'd0, OutValid}, 48'd0);
        check_eq("rst_hi", {24'd0, Hi}, 48'd0);
        check_eq("rst_flags", {45'd0, Flags}, 48'd0);
        Reset = 1'b0;
        step();
        check_eq("rst_inready", {47'd0, InReady}, 48'd1);

        // Basic capture then stall for three cycles
        InValid = 1'b1; Result_final = 24'h00ABCD; RdIn = 4'd5; RegWriteIn = 1'b1;
        step();
        check_eq("cap_valid", {47'd0, OutValid}, 48'd1);
        check_eq("cap_data", {24'd0, WbData}, 48'h00ABCD);
        check_eq("cap_rd", {44'd0, WbRd}, 48'd5);
        check_eq("cap_we", {47'd0, WbRegWrite}, 48'd1);
        OutReady = 1'b0; Result_final = 24'h123456; RdIn = 4'd7;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_inready", {47'd0, InReady}, 48'd0);
            step();
            check_eq("stall_data", {24'd0, WbData}, 48'h00ABCD);
            check_eq("stall_rd", {44'd0, WbRd}, 48'd5);
            check_eq("stall_valid", {47'd0, OutValid}, 48'd1);
        end
        OutReady = 1'b1;
        step();
        check_eq("drain_cap_data", {24'd0, WbData}, 48'h123456);
        check_eq("drain_cap_rd", {44'd0, WbRd}, 48'd7);
        InValid = 1'b0;
        step();
        check_eq("drain_valid", {47'd0, OutValid}, 48'd0);
        check_eq("drain_we", {47'd0, WbRegWrite}, 48'd0);

        // MUL followed by MFHI / MFLO
        InValid = 1'b1; MulWrite = 1'b1; Mul_result = 48'h000001_FFFFFE;
        Result_final = 24'h000000; RegWriteIn = 1'b0;
        step();
        check_eq("mul_hi", {24'd0, Hi}, 48'h000001);
        check_eq("mul_lo", {24'd0, Lo}, 48'hFFFFFE);
        MulWrite = 1'b0; MfHi = 1'b1; RegWriteIn = 1'b1; RdIn = 4'd2;
        step();
        check_eq("mfhi_data", {24'd0, WbData}, 48'h000001);
        MfHi = 1'b0; MfLo = 1'b1;
        step();
        check_eq("mflo_data", {24'd0, WbData}, 48'hFFFFFE);
        MfHi = 1'b1; MfLo = 1'b1; MulWrite = 1'b1; Mul_result = 48'hAAAAAA_555555;
        step();
        check_eq("mfhi_prio_old", {24'd0, WbData}, 48'h000001);
        check_eq("mul2_hi", {24'd0, Hi}, 48'hAAAAAA);
        check_eq("mul2_lo", {24'd0, Lo}, 48'h555555);

        // Overflow trap
        MfHi = 1'b0; MfLo = 1'b0; MulWrite = 1'b0;
        Result_final = 24'h800000; Overflow = 1'b1; TrapEn = 1'b1; FlagWrite = 1'b1;
        step();
        check_eq("trap_pulse", {47'd0, OverflowTrap}, 48'd1);
        check_eq("trap_we", {47'd0, WbRegWrite}, 48'd0);
        check_eq("trap_valid", {47'd0, OutValid}, 48'd1);
        check_eq("trap_flags", {45'd0, Flags}, 48'b100);
        check_eq("trap_data", {24'd0, WbData}, 48'h800000);
        InValid = 1'b0; Overflow = 1'b0; TrapEn = 1'b0; FlagWrite = 1'b0;
        step();
        check_eq("trap_gone", {47'd0, OverflowTrap}, 48'd0);
        check_eq("trap_drain", {47'd0, OutValid}, 48'd0);
        check_eq("flags_sticky", {45'd0, Flags}, 48'b100);

        // Flags from carry/zero without trap
        InValid = 1'b1; FlagWrite = 1'b1; Zero = 1'b1; CarryOut = 1'b1; Result_final = 24'h000000;
        step();
        check_eq("cz_flags", {45'd0, Flags}, 48'b011);
        check_eq("cz_notrap", {47'd0, OverflowTrap}, 48'd0);
        check_eq("cz_we", {47'd0, WbRegWrite}, 48'd1);

        // Flush with held entry and a same-cycle MUL/trap candidate
        Zero = 1'b0; CarryOut = 1'b0;
        Flush = 1'b1; MulWrite = 1'b1; Mul_result = 48'h123456_654321; Overflow = 1'b1; TrapEn = 1'b1;
        step();
        check_eq("flush_valid", {47'd0, OutValid}, 48'd0);
        check_eq("flush_we", {47'd0, WbRegWrite}, 48'd0);
        check_eq("flush_hi", {24'd0, Hi}, 48'hAAAAAA);
        check_eq("flush_lo", {24'd0, Lo}, 48'h555555);
        check_eq("flush_notrap", {47'd0, OverflowTrap}, 48'd0);
        check_eq("flush_flags", {45'd0, Flags}, 48'b011);
        idle_inputs();

        // Back-to-back stream of four entries
        for (int i = 0; i < 4; i++) begin
            InValid = 1'b1; RegWriteIn = 1'b1; RdIn = 4'(i + 8);
            Result_final = 24'h000010 + 24'(i);
            #1;
            check_eq("stream_inready", {47'd0, InReady}, 48'd1);
            step();
            check_eq("stream_valid", {47'd0, OutValid}, 48'd1);
            check_eq("stream_data", {24'd0, WbData}, 48'h000010 + 48'(i));
            check_eq("stream_rd", {44'd0, WbRd}, 48'(i + 8));
        end
        idle_inputs();
        step();
        check_eq("stream_end", {47'd0, OutValid}, 48'd0);

        // Reset while an entry is held
        InValid = 1'b1; RegWriteIn = 1'b1; RdIn = 4'd3; Result_final = 24'h0F0F0F; OutReady = 1'b0;
        step();
        InValid = 1'b0;
        check_eq("pre_rst_valid", {47'd0, OutValid}, 48'd1);
        #2;
        Reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", {47'd0, OutValid}, 48'd0);
        check_eq("mid_rst_we", {47'd0, WbRegWrite}, 48'd0);
        check_eq("mid_rst_data", {24'd0, WbData}, 48'd0);
        check_eq("mid_rst_rd", {44'd0, WbRd}, 48'd0);
        check_eq("mid_rst_hi", {24'd0, Hi}, 48'd0);
        check_eq("mid_rst_lo", {24'd0, Lo}, 48'd0);
        check_eq("mid_rst_flags", {45'd0, Flags}, 48'd0);
        step();
        Reset = 1'b0;
        step();
        check_eq("post_rst_inready", {47'd0, InReady}, 48'd1);
        check_eq("post_rst_valid", {47'd0, OutValid}, 48'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
